// File: rtl/line_frame_ctrl.sv
// line_frame_ctrl: buffers pixel words in a skid FIFO and frames each line as sync, header, payload and XOR trailer
module line_frame_ctrl #(
  parameter int          WORDS_PER_LINE = 1536,
  parameter logic [31:0] SYNC_WORD      = 32'hA5A5_5A5A,
  parameter int          SKID_DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [31:0] PIX_DIN,
  input  logic        PIX_DIN_DV,
  input  logic        PIX_OVRF,
  output logic        PIX_AFULL,
  output logic [31:0] DOUT,
  output logic        DOUT_DV,
  input  logic        DOUT_AFULL,
  output logic [23:0] LINE_CNT,
  output logic        SKID_OVRF,
  output logic        BUSY
);
  localparam int AW = $clog2(SKID_DEPTH);
  typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_LINE, PAYLOAD, TRAILER} state_t;
  state_t state;
  logic [31:0] skid [SKID_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [23:0] word_cnt;
  logic [31:0] acc;
  logic f_pix, f_skid;
  logic full, push, drop, pop, hdr_emit, last;
  assign full     = level == (AW+1)'(SKID_DEPTH);
  assign push     = PIX_DIN_DV && !full;
  assign drop     = PIX_DIN_DV && full;
  assign pop      = state == PAYLOAD && !DOUT_AFULL && level != '0;
  assign hdr_emit = state == HDR_LINE && !DOUT_AFULL;
  assign last     = word_cnt == 24'(WORDS_PER_LINE - 1);
  assign BUSY     = state != IDLE;
  always_ff @(posedge CLK)
    if (push) skid[wr_ptr] <= PIX_DIN;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      DOUT      <= '0;
      DOUT_DV   <= 1'b0;
      LINE_CNT  <= '0;
      SKID_OVRF <= 1'b0;
      PIX_AFULL <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      word_cnt  <= '0;
      acc       <= '0;
      f_pix     <= 1'b0;
      f_skid    <= 1'b0;
    end else begin
      PIX_AFULL <= !ENABLE || state != PAYLOAD || DOUT_AFULL || level >= (AW+1)'(SKID_DEPTH - 4);
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      level     <= level + (AW+1)'(push) - (AW+1)'(pop);
      SKID_OVRF <= SKID_OVRF | drop;
      f_pix     <= (f_pix && !hdr_emit) || PIX_OVRF;
      f_skid    <= (f_skid && !hdr_emit) || drop;
      DOUT_DV   <= 1'b0;
      case (state)
        IDLE: if (ENABLE) state <= HDR_SYNC;
        HDR_SYNC: if (!DOUT_AFULL) begin
          DOUT    <= SYNC_WORD;
          DOUT_DV <= 1'b1;
          state   <= HDR_LINE;
        end
        HDR_LINE: if (hdr_emit) begin
          DOUT    <= {6'b0, f_skid, f_pix, LINE_CNT};
          DOUT_DV <= 1'b1;
          state   <= PAYLOAD;
        end
        PAYLOAD: if (pop) begin
          DOUT     <= skid[rd_ptr];
          DOUT_DV  <= 1'b1;
          acc      <= acc ^ skid[rd_ptr];
          word_cnt <= last ? '0 : word_cnt + 24'd1;
          state    <= last ? TRAILER : PAYLOAD;
        end
        TRAILER: if (!DOUT_AFULL) begin
          DOUT     <= acc;
          DOUT_DV  <= 1'b1;
          acc      <= '0;
          LINE_CNT <= LINE_CNT + 24'd1;
          state    <= ENABLE ? HDR_SYNC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/line_frame_ctrl.md
# line_frame_ctrl

Output-side sequencer for the line-scan pixel path. Consumes the packed 32-bit RGB word stream from the pixel buffer, throttles it through the buffer's AFULL input, and frames each scan line as a packet for the downstream FIFO/DMA. Each packet is a sync word, a header carrying the line number and status, a fixed-length payload, and an XOR checksum trailer.

## Interface
- WORDS_PER_LINE, 1536, payload words per line; range 1..2^24-1.
- SYNC_WORD, 32'hA5A5_5A5A, first word of every packet.
- SKID_DEPTH, 8, depth of the internal skid FIFO in words; power of two, ≥8.
- CLK  in  1  single clock for the whole block.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  level; 1 = produce packets.
- PIX_DIN  in  32  packed pixel word from the pixel buffer.
- PIX_DIN_DV  in  1  PIX_DIN valid.
- PIX_OVRF  in  1  pixel-buffer FIFO overflow pulse.
- PIX_AFULL  out  1  throttle to the pixel buffer; 1 = stop reading.
- DOUT  out  32  framed output word.
- DOUT_DV  out  1  DOUT valid.
- DOUT_AFULL  in  1  downstream almost-full.
- LINE_CNT  out  24  number of completed packets.
- SKID_OVRF  out  1  sticky: a skid write was dropped. Cleared only by RST.
- BUSY  out  1  1 when the state is not IDLE.

## Operation
- The upstream keeps delivering for up to 3 cycles after PIX_AFULL rises. The skid FIFO absorbs these words.
- PIX_AFULL = ~ENABLE | (state≠PAYLOAD) | DOUT_AFULL | (skid level ≥ SKID_DEPTH−4). The output is registered.
- Skid write when the skid is full: the word is dropped, SKID_OVRF=1, and line flag f_skid=1.
- PIX_OVRF=1 in any cycle sets line flag f_pix.
- States: IDLE, HDR_SYNC, HDR_LINE, PAYLOAD, TRAILER.
  - IDLE: ENABLE=1 → HDR_SYNC.
  - HDR_SYNC: emit SYNC_WORD → HDR_LINE.
  - HDR_LINE: emit {6'b0, prev_f_skid, prev_f_pix, LINE_CNT[23:0]} → PAYLOAD. Copy the line flags to prev_* and clear the line flags. A flag event in this same cycle is kept in the new line flags.
  - PAYLOAD: pop the skid and emit one word per cycle when the skid is non-empty. Accumulate the XOR of the payload words. After WORDS_PER_LINE words → TRAILER.
  - TRAILER: emit the XOR accumulator, clear the accumulator, LINE_CNT+1. Go to HDR_SYNC if ENABLE=1, else IDLE.
- A word is emitted only in a cycle where DOUT_AFULL=0. Otherwise the state holds and nothing is popped.
- ENABLE falling mid-packet does not abort: the packet completes, then the block goes to IDLE.
- Words arriving while in IDLE or header states are held in the skid, not discarded.
- LINE_CNT wraps from 2^24−1 to 0. The payload word counter is 24 bits.

## Timing
- Reset values:
  - PIX_AFULL=1
  - DOUT=0, DOUT_DV=0
  - LINE_CNT=0
  - SKID_OVRF=0
  - BUSY=0
  - state=IDLE
  - skid empty, accumulator 0, all flags 0.
- DOUT and DOUT_DV are registered. A word is decided in cycle n and appears in cycle n+1.
- Input to output: PIX_DIN_DV in cycle n → skid write at the n edge → earliest DOUT_DV in cycle n+2 (PAYLOAD, DOUT_AFULL=0).
- HDR_SYNC is entered the cycle after ENABLE=1 is sampled. The first DOUT_DV (SYNC_WORD) comes 2 cycles after ENABLE rises.
- Minimum packet duration is WORDS_PER_LINE+3 cycles, with no idle cycles between back-to-back packets.
- A skid push and pop in the same cycle leave the level unchanged. A push into a full skid is dropped even if a pop happens in the same cycle.
- RST mid-packet discards the partial packet and returns every register to its reset value on the next edge.

## Test plan
1. WORDS_PER_LINE=4, ENABLE=1, feed 1,2,3,4 continuously, DOUT_AFULL=0.
   - Expect A5A55A5A, 00000000, 1, 2, 3, 4, 00000004.
   - LINE_CNT=1. The second packet header is 00000001.
2. DOUT_AFULL held high for 20 cycles mid-payload, upstream streaming.
   - DOUT_DV=0 throughout; PIX_AFULL=1 within 1 cycle.
   - 3 in-flight words land in the skid; no SKID_OVRF; payload order is intact after release.
3. Push SKID_DEPTH+1 words while in HDR_SYNC, ignoring PIX_AFULL.
   - SKID_OVRF=1, one word dropped.
   - The next header has bit25=1; the header after that has bit25=0.
4. PIX_OVRF pulse during line k.
   - The header of line k+1 has bit24=1.
5. ENABLE=0 at payload word 2 of 4.
   - The packet completes with trailer, then IDLE: BUSY=0, PIX_AFULL=1, no further DOUT_DV.
6. RST asserted at payload word 3, then ENABLE.
   - LINE_CNT=0, and the next output is SYNC_WORD followed by header 00000000.
